vga_cfg_mb: RTL and testbench
=============================

# vga_cfg_mb

APB4 configuration/status register block for the VGA controller, successor to the fixed two-buffer config block. Parametrised framebuffer ring depth and pixel-divider width. Adds frame-synchronous shadowing of timing registers, W1C interrupt flags and an optional underrun counter. Sits between the APB4 fabric and the VGA timing generator and pixel fetch engine.

## Interface
- FB_NUM, 2, framebuffer base registers in the ring (2..8)
- DIV_WIDTH, 8, pixel clock divider width (4..16)
- apb4.pclk  in  1  clock; all logic single-domain
- apb4.presetn  in  1  reset, synchronous, active-low
- apb4  apb4_if.slave  -  paddr/psel/penable/pwrite/pwdata/prdata/pready/pslverr; pready=1, pslverr=0
- frame_start_i  in  1  one-cycle pulse at first pixel-clock cycle of a frame
- horirq_i / verirq_i / vbsirq_i  in  1  one-cycle event pulses from the timing generator
- uflow_i  in  1  one-cycle pixel FIFO underrun pulse
- ctrl_o  out  vga_ctrl_t  live CTRL fields
- hvvl_o / htim_o / vtim_o  out  32/24/24  shadowed timing values
- fbba_o  out  32  base address of the current framebuffer
- fb_idx_o  out  3  current ring index
- pclk_en_o  out  1  pixel clock enable
- irq_o  out  1  interrupt request

## Operation
- Address word = paddr[5:2]. 0 CTRL, 1 HVVL, 2 HTIM, 3 VTIM, 4 STAT, 5 FBCTRL, 6 UFLOW, 8..8+FB_NUM-1 FBBA[i]. Unmapped words read 0; writes to them are ignored.
- Write on psel&penable&pwrite. prdata is valid on psel&penable&~pwrite and is 0 otherwise.
- CTRL bits: en[0], hie[1], vie[2], vbsie[3], vbse[4], blpol[5], hspol[6], vspol[7], test[8], mode[10:9], uie[11], div[16+DIV_WIDTH-1:16]. Other bits read 0.
- Timing shadow:
  - Writes to HVVL/HTIM/VTIM go to staging registers and set `pending`.
  - en=1: on frame_start_i with pending, staging is copied to the outputs and pending clears.
  - en=0: the copy happens on the next cycle unconditionally.
  - Reads return staging.
- STAT: hif[0], vif[1], vbsif[2], uif[3] (W1C), pending[4] (RO), fb_idx[7:5] (RO).
  - A flag sets on its input pulse and clears on an APB write of 1 to its bit.
  - Set and clear in the same cycle: set wins.
- irq_o = |(flags & {uie,vbsie,vie,hie}).
- FBCTRL:
  - last[2:0] is RW; a written value above FB_NUM-1 is clamped to FB_NUM-1.
  - cur[10:8] is RO.
  - Any FBCTRL write resets cur to 0.
  - On vbsirq_i with vbse=1: cur = (cur==last) ? 0 : cur+1.
  - FBCTRL write and vbsirq_i in the same cycle: the write wins.
- fbba_o = FBBA[cur]; FBBA[i] bits [1:0] read 0 (word aligned).
- Divider:
  - Effective div = (div==0) ? 1 : div.
  - cnt counts 0..div-1 and wraps; pclk_en_o = (cnt==0).
  - A CTRL write resets cnt to 0.

## Timing
- Reset (presetn low at a clock edge) zeroes all registers, flags, pending, cur and cnt. After reset: irq_o=0, ctrl_o=0, shadow outputs 0, fbba_o=0, fb_idx_o=0, pclk_en_o=1.
- Register writes are visible on the outputs one cycle after the write cycle, except shadowed timing values.
- Event pulse at cycle N gives flag=1 and irq_o=1 at N+1.
- frame_start_i at cycle N with pending gives new shadow outputs at N+1.
- Write to a timing register and frame_start_i in the same cycle:
  - The copy uses the pre-write staging value.
  - pending stays set, so the new value applies at the next frame.
- Back-to-back APB transfers are supported at full rate with zero wait states.

## Configuration
- VGA_CFG_UFLOW_EN defined:
  - UFLOW holds a 16-bit saturating count of uflow_i pulses (holds at 0xFFFF).
  - Any write to UFLOW clears it; write and pulse in the same cycle gives 1.
  - uif and uie are functional.
- VGA_CFG_UFLOW_EN undefined:
  - UFLOW reads 0, uif reads 0, uie is writable but has no effect, uflow_i is ignored.

## Structure
- Shared package vga_pkg holds:
  - register word offsets;
  - vga_ctrl_t packed struct;
  - STAT bit positions;
  - FB_NUM and DIV_WIDTH limits.
- One sub-module, vga_pclk_div (parameter DIV_WIDTH). Inputs: div, restart. Output: pclk_en.
- The dffer/dffr register primitives must be synchronous-reset variants.

## Test plan
- Reset, then read all words: all 0. pclk_en_o=1 every cycle (div=0 is treated as 1).
- CTRL.div=3: pclk_en_o is high for 1 cycle in every 3. Rewrite CTRL: pclk_en_o=1 on the next cycle.
- en=1, write HTIM=0x00_0A05_10: htim_o holds its old value and STAT[4]=1 until frame_start_i. The cycle after frame_start_i: htim_o=0x0A0510, STAT[4]=0.
- FB_NUM=4, FBCTRL.last=2, vbse=1, 5 vbsirq_i pulses: fb_idx_o sequence 1,2,0,1,2; fbba_o tracks FBBA[idx]. Write last=7: reads back 3.
- hie=1, horirq_i pulse: irq_o=1 next cycle. Write STAT=1 coincident with another horirq_i: flag stays 1. Write STAT=1 alone: irq_o=0 next cycle.
- With VGA_CFG_UFLOW_EN: 0x10005 uflow_i pulses saturate UFLOW at 0xFFFF; a write clears it to 0. Without the macro: UFLOW reads 0.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared definitions for the VGA configuration register block
// Contents: register word offsets, STAT bit positions, parameter limits,
// and the CTRL field layout (vga_ctrl_t) driven onto ctrl_o.
package vga_pkg;

  localparam int FB_NUM_MIN    = 2;
  localparam int FB_NUM_MAX    = 8;
  localparam int DIV_WIDTH_MIN = 4;
  localparam int DIV_WIDTH_MAX = 16;

  // Word offsets (paddr[5:2])
  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_HVVL   = 4'd1;
  localparam logic [3:0] REG_HTIM   = 4'd2;
  localparam logic [3:0] REG_VTIM   = 4'd3;
  localparam logic [3:0] REG_STAT   = 4'd4;
  localparam logic [3:0] REG_FBCTRL = 4'd5;
  localparam logic [3:0] REG_UFLOW  = 4'd6;
  localparam logic [3:0] REG_FBBA0  = 4'd8;

  // STAT bit positions
  localparam int STAT_HIF     = 0;
  localparam int STAT_VIF     = 1;
  localparam int STAT_VBSIF   = 2;
  localparam int STAT_UIF     = 3;
  localparam int STAT_PEND    = 4;
  localparam int STAT_IDX_LSB = 5;

  // div is sized for the widest divider; bits above DIV_WIDTH stay zero
  typedef struct packed {
    logic [DIV_WIDTH_MAX-1:0] div;
    logic                     uie;
    logic [1:0]               mode;
    logic                     test;
    logic                     vspol;
    logic                     hspol;
    logic                     blpol;
    logic                     vbse;
    logic                     vbsie;
    logic                     vie;
    logic                     hie;
    logic                     en;
  } vga_ctrl_t;

endpackage

// File: rtl/apb4_if.sv
// rtl/apb4_if.sv - APB4 bus bundle with master/slave modports
// Ports: pclk, presetn (sync active-low). Members: paddr, psel, penable,
// pwrite, pwdata, prdata, pready, pslverr.
interface apb4_if (
  input logic pclk,
  input logic presetn
);

  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    input  pclk, presetn, prdata, pready, pslverr,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    input  pclk, presetn, paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/vga_pclk_div.sv
// rtl/vga_pclk_div.sv - pixel clock enable divider
// Ports: clk, resetn (sync active-low), div (0 treated as 1),
// restart (forces count back to 0), pclk_en (high when count is 0).
module vga_pclk_div #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 restart,
  output logic                 pclk_en
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] cnt_top;

  assign cnt_top = (div == '0) ? '0 : div - 1'b1;

  // >= rather than == so a count left above a smaller divisor still wraps
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (restart || (cnt >= cnt_top)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign pclk_en = (cnt == '0);

endmodule

// File: rtl/vga_cfg_mb.sv
// rtl/vga_cfg_mb.sv - APB4 configuration/status registers for the VGA controller
// Ports: apb (apb4_if.slave, carries pclk/presetn), frame_start_i, horirq_i,
// verirq_i, vbsirq_i, uflow_i event pulses; ctrl_o, hvvl_o/htim_o/vtim_o
// shadowed timing, fbba_o/fb_idx_o framebuffer ring, pclk_en_o, irq_o.
// Optional feature: define VGA_CFG_UFLOW_EN for the underrun counter/flag.
module vga_cfg_mb
  import vga_pkg::*;
#(
  parameter int FB_NUM    = 2,
  parameter int DIV_WIDTH = 8
) (
  apb4_if.slave       apb,
  input  logic        frame_start_i,
  input  logic        horirq_i,
  input  logic        verirq_i,
  input  logic        vbsirq_i,
  input  logic        uflow_i,
  output vga_ctrl_t   ctrl_o,
  output logic [31:0] hvvl_o,
  output logic [23:0] htim_o,
  output logic [23:0] vtim_o,
  output logic [31:0] fbba_o,
  output logic [2:0]  fb_idx_o,
  output logic        pclk_en_o,
  output logic        irq_o
);

  localparam int FBN = (FB_NUM < FB_NUM_MIN) ? FB_NUM_MIN :
                       (FB_NUM > FB_NUM_MAX) ? FB_NUM_MAX : FB_NUM;
  localparam int DW  = (DIV_WIDTH < DIV_WIDTH_MIN) ? DIV_WIDTH_MIN :
                       (DIV_WIDTH > DIV_WIDTH_MAX) ? DIV_WIDTH_MAX : DIV_WIDTH;
  localparam logic [2:0] LAST_MAX = 3'(FBN - 1);
  localparam logic [3:0] FB_CNT   = 4'(FBN);

  logic clk, resetn;
  assign clk    = apb.pclk;
  assign resetn = apb.presetn;

  logic [3:0]  word;
  logic [31:0] wdata;
  logic        wr, rd;
  logic [2:0]  fb_sel;
  logic        fb_hit;

  assign word   = apb.paddr[5:2];
  assign wdata  = apb.pwdata;
  assign wr     = apb.psel & apb.penable & apb.pwrite;
  assign rd     = apb.psel & apb.penable & ~apb.pwrite;
  assign fb_sel = 3'(word - REG_FBBA0);
  assign fb_hit = (word >= REG_FBBA0) && ({1'b0, fb_sel} < FB_CNT);

  logic wr_ctrl, wr_hvvl, wr_htim, wr_vtim, wr_stat, wr_fbctrl, wr_uflow;
  assign wr_ctrl   = wr && (word == REG_CTRL);
  assign wr_hvvl   = wr && (word == REG_HVVL);
  assign wr_htim   = wr && (word == REG_HTIM);
  assign wr_vtim   = wr && (word == REG_VTIM);
  assign wr_stat   = wr && (word == REG_STAT);
  assign wr_fbctrl = wr && (word == REG_FBCTRL);
  assign wr_uflow  = wr && (word == REG_UFLOW);

  // ---------------- CTRL ----------------
  vga_ctrl_t ctrl_q, ctrl_wr;

  always_comb begin
    ctrl_wr               = '0;
    ctrl_wr.en            = wdata[0];
    ctrl_wr.hie           = wdata[1];
    ctrl_wr.vie           = wdata[2];
    ctrl_wr.vbsie         = wdata[3];
    ctrl_wr.vbse          = wdata[4];
    ctrl_wr.blpol         = wdata[5];
    ctrl_wr.hspol         = wdata[6];
    ctrl_wr.vspol         = wdata[7];
    ctrl_wr.test          = wdata[8];
    ctrl_wr.mode          = wdata[10:9];
    ctrl_wr.uie           = wdata[11];
    ctrl_wr.div[DW-1:0]   = wdata[16 +: DW];
  end

  always_ff @(posedge clk) begin
    if (!resetn)      ctrl_q <= '0;
    else if (wr_ctrl) ctrl_q <= ctrl_wr;
  end

  assign ctrl_o = ctrl_q;

  // ---------------- timing staging + shadow ----------------
  logic [31:0] hvvl_s;
  logic [23:0] htim_s, vtim_s;
  logic        pending;
  logic        copy;

  // While disabled the shadows simply follow staging one cycle late.
  assign copy = ~ctrl_q.en | (frame_start_i & pending);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hvvl_s  <= '0;
      htim_s  <= '0;
      vtim_s  <= '0;
      hvvl_o  <= '0;
      htim_o  <= '0;
      vtim_o  <= '0;
      pending <= 1'b0;
    end else begin
      // Copy takes pre-write staging; a coincident write keeps pending set
      if (copy) begin
        hvvl_o <= hvvl_s;
        htim_o <= htim_s;
        vtim_o <= vtim_s;
      end
      if (wr_hvvl) hvvl_s <= wdata;
      if (wr_htim) htim_s <= wdata[23:0];
      if (wr_vtim) vtim_s <= wdata[23:0];
      if (wr_hvvl | wr_htim | wr_vtim) pending <= 1'b1;
      else if (copy)                   pending <= 1'b0;
    end
  end

  // ---------------- underrun counter (optional) ----------------
  logic [15:0] ucnt;
  logic        uflow_ev;
  logic        uie_ev;

`ifdef VGA_CFG_UFLOW_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ucnt <= '0;
    end else if (wr_uflow) begin
      ucnt <= {15'd0, uflow_i};
    end else if (uflow_i && (ucnt != 16'hFFFF)) begin
      ucnt <= ucnt + 16'd1;
    end
  end
  assign uflow_ev = uflow_i;
  assign uie_ev   = ctrl_q.uie;
`else
  assign ucnt     = '0;
  assign uflow_ev = 1'b0;
  assign uie_ev   = 1'b0;
  logic unused_uflow;
  assign unused_uflow = uflow_i ^ wr_uflow;
`endif

  // ---------------- STAT flags / irq ----------------
  logic [3:0] flags, flag_set, flag_clr, flag_ie;

  assign flag_set = {uflow_ev, vbsirq_i, verirq_i, horirq_i};
  assign flag_clr = wr_stat ? wdata[3:0] : 4'd0;
  assign flag_ie  = {uie_ev, ctrl_q.vbsie, ctrl_q.vie, ctrl_q.hie};

  // Set is OR'd in after the clear so a coincident event wins
  always_ff @(posedge clk) begin
    if (!resetn) flags <= '0;
    else         flags <= (flags & ~flag_clr) | flag_set;
  end

  assign irq_o = |(flags & flag_ie);

  // ---------------- framebuffer ring ----------------
  logic [2:0]  last, cur;
  logic [31:2] fbba [FB_NUM_MAX];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last <= '0;
      cur  <= '0;
    end else if (wr_fbctrl) begin
      last <= (wdata[2:0] > LAST_MAX) ? LAST_MAX : wdata[2:0];
      cur  <= '0;
    end else if (vbsirq_i && ctrl_q.vbse) begin
      cur  <= (cur == last) ? 3'd0 : cur + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < FB_NUM_MAX; i++) fbba[i] <= '0;
    end else if (wr && fb_hit) begin
      fbba[fb_sel] <= wdata[31:2];
    end
  end

  assign fbba_o   = {fbba[cur], 2'b00};
  assign fb_idx_o = cur;

  // ---------------- pixel clock divider ----------------
  vga_pclk_div #(
    .DIV_WIDTH (DW)
  ) u_pclk_div (
    .clk     (clk),
    .resetn  (resetn),
    .div     (ctrl_q.div[DW-1:0]),
    .restart (wr_ctrl),
    .pclk_en (pclk_en_o)
  );

  // ---------------- read mux ----------------
  logic [31:0] stat_word;
  logic [31:0] prdata_r;

  always_comb begin
    stat_word                             = '0;
    stat_word[STAT_HIF]                   = flags[0];
    stat_word[STAT_VIF]                   = flags[1];
    stat_word[STAT_VBSIF]                 = flags[2];
    stat_word[STAT_UIF]                   = flags[3];
    stat_word[STAT_PEND]                  = pending;
    stat_word[STAT_IDX_LSB +: 3]          = cur;
  end

  always_comb begin
    prdata_r = '0;
    if (rd) begin
      case (word)
        REG_CTRL:   prdata_r = {ctrl_q.div, 4'd0, ctrl_q.uie, ctrl_q.mode, ctrl_q.test,
                                ctrl_q.vspol, ctrl_q.hspol, ctrl_q.blpol, ctrl_q.vbse,
                                ctrl_q.vbsie, ctrl_q.vie, ctrl_q.hie, ctrl_q.en};
        REG_HVVL:   prdata_r = hvvl_s;
        REG_HTIM:   prdata_r = {8'd0, htim_s};
        REG_VTIM:   prdata_r = {8'd0, vtim_s};
        REG_STAT:   prdata_r = stat_word;
        REG_FBCTRL: prdata_r = {21'd0, cur, 5'd0, last};
        REG_UFLOW:  prdata_r = {16'd0, ucnt};
        default:    prdata_r = fb_hit ? {fbba[fb_sel], 2'b00} : 32'd0;
      endcase
    end
  end

  assign apb.prdata  = prdata_r;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = 1'b0;

  logic unused;
  assign unused = ^{apb.paddr[31:6], apb.paddr[1:0], apb.pwdata};

endmodule

// File: tb/tb_vga_cfg_mb.sv
// tb/tb_vga_cfg_mb.sv - self-checking bench for vga_cfg_mb against a register-level model
module tb_vga_cfg_mb;

  localparam int FBN = 4;
  localparam int DW  = 8;
`ifdef VGA_CFG_UFLOW_EN
  localparam bit UF = 1'b1;
`else
  localparam bit UF = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  apb4_if apb (.pclk(clk), .presetn(rstn));

  logic              frame_start, hor, ver, vbs, uflow;
  vga_pkg::vga_ctrl_t ctrl_o;
  logic [31:0]       hvvl_o, fbba_o;
  logic [23:0]       htim_o, vtim_o;
  logic [2:0]        fb_idx_o;
  logic              pclk_en_o, irq_o;

  vga_cfg_mb #(.FB_NUM(FBN), .DIV_WIDTH(DW)) dut (
    .apb           (apb),
    .frame_start_i (frame_start),
    .horirq_i      (hor),
    .verirq_i      (ver),
    .vbsirq_i      (vbs),
    .uflow_i       (uflow),
    .ctrl_o        (ctrl_o),
    .hvvl_o        (hvvl_o),
    .htim_o        (htim_o),
    .vtim_o        (vtim_o),
    .fbba_o        (fbba_o),
    .fb_idx_o      (fb_idx_o),
    .pclk_en_o     (pclk_en_o),
    .irq_o         (irq_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents as the software sees them
  logic [31:0] m_ctrl = '0;
  logic [31:0] m_stage [3] = '{default: '0};
  logic [31:0] m_shadow[3] = '{default: '0};
  logic        m_pend = 1'b0;
  logic [3:0]  m_flags = '0;
  int          m_last = 0, m_cur = 0, m_ucnt = 0, m_t = 0;
  logic [31:0] m_fbba [8] = '{default: '0};
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    int w;
    w = int'(a[5:2]);
    case (w)
      0: return m_ctrl;
      1, 2, 3: return m_stage[w-1];
      4: return {24'd0, 3'(m_cur), m_pend, m_flags};
      5: return {21'd0, 3'(m_cur), 5'd0, 3'(m_last)};
      6: return UF ? 32'(m_ucnt) : 32'd0;
      default: return (w >= 8 && w - 8 < FBN) ? m_fbba[w-8] : 32'd0;
    endcase
  endfunction

  // ev bits: [0] frame_start, [1] hor, [2] ver, [3] vbs, [4] uflow
  task automatic model_edge(input logic wr, input logic [5:0] a, input logic [31:0] d, input logic [4:0] ev);
    int w, dv;
    logic cp;
    logic [3:0] clr;
    if (!rstn) begin
      m_ctrl = '0; m_pend = 0; m_flags = '0; m_last = 0; m_cur = 0; m_ucnt = 0; m_t = 0;
      for (int i = 0; i < 3; i++) begin m_stage[i] = '0; m_shadow[i] = '0; end
      for (int i = 0; i < 8; i++) m_fbba[i] = '0;
      return;
    end
    w  = int'(a[5:2]);
    cp = (m_ctrl[0] == 1'b0) || (ev[0] && m_pend);
    if (cp) for (int i = 0; i < 3; i++) m_shadow[i] = m_stage[i];
    clr = (wr && w == 4) ? d[3:0] : 4'd0;
    m_flags = (m_flags & ~clr) | {UF & ev[4], ev[3], ev[2], ev[1]};
    if (wr && w == 5) begin
      m_last = (int'(d[2:0]) > FBN - 1) ? FBN - 1 : int'(d[2:0]);
      m_cur  = 0;
    end else if (ev[3] && m_ctrl[4]) begin
      m_cur = (m_cur == m_last) ? 0 : m_cur + 1;
    end
    if (wr && w == 6)               m_ucnt = ev[4] ? 1 : 0;
    else if (ev[4] && m_ucnt < 65535) m_ucnt = m_ucnt + 1;
    if (wr && w == 0) m_t = 0; else m_t = m_t + 1;
    if (wr) begin
      dv = (1 << DW) - 1;
      if (w == 0) m_ctrl = d & (32'hFFF | (32'(dv) << 16));
      if (w == 1) m_stage[0] = d;
      if (w == 2) m_stage[1] = d & 32'hFFFFFF;
      if (w == 3) m_stage[2] = d & 32'hFFFFFF;
      if (w >= 8 && w - 8 < FBN) m_fbba[w-8] = d & 32'hFFFFFFFC;
    end
    if (wr && (w >= 1 && w <= 3)) m_pend = 1'b1;
    else if (cp)                  m_pend = 1'b0;
  endtask

  task automatic check_outputs();
    int eff;
    eff = int'(m_ctrl[16 +: DW]);
    if (eff == 0) eff = 1;
    chk("ctrl_o",    {4'd0, ctrl_o}, {4'd0, m_ctrl[31:16], m_ctrl[11:0]});
    chk("hvvl_o",    hvvl_o, m_shadow[0]);
    chk("htim_o",    {8'd0, htim_o}, m_shadow[1]);
    chk("vtim_o",    {8'd0, vtim_o}, m_shadow[2]);
    chk("fbba_o",    fbba_o, m_fbba[m_cur]);
    chk("fb_idx_o",  {29'd0, fb_idx_o}, 32'(m_cur));
    chk("pclk_en_o", {31'd0, pclk_en_o}, {31'd0, (m_t % eff) == 0});
    chk("irq_o",     {31'd0, irq_o},
        {31'd0, |(m_flags & {UF & m_ctrl[11], m_ctrl[3], m_ctrl[2], m_ctrl[1]})});
  endtask

  task automatic tick(input logic ps, input logic pe, input logic pw, input logic [5:0] a,
                      input logic [31:0] d, input logic [4:0] ev);
    apb.psel = ps; apb.penable = pe; apb.pwrite = pw;
    apb.paddr = {26'd0, a}; apb.pwdata = d;
    frame_start = ev[0]; hor = ev[1]; ver = ev[2]; vbs = ev[3]; uflow = ev[4];
    #1;
    if (ps && pe && !pw) begin
      last_rd = apb.prdata;
      chk("prdata", apb.prdata, m_read(a));
    end else begin
      chk("prdata_idle", apb.prdata, 32'd0);
    end
    @(posedge clk);
    model_edge(ps & pe & pw, a, d, ev);
    #1;
    check_outputs();
  endtask

  task automatic apb_write(input logic [5:0] a, input logic [31:0] d, input logic [4:0] ev);
    tick(1'b1, 1'b0, 1'b1, a, d, 5'd0);
    tick(1'b1, 1'b1, 1'b1, a, d, ev);
  endtask

  task automatic apb_read(input logic [5:0] a);
    tick(1'b1, 1'b0, 1'b0, a, 32'd0, 5'd0);
    tick(1'b1, 1'b1, 1'b0, a, 32'd0, 5'd0);
  endtask

  task automatic idle(input int n, input logic [4:0] ev);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, ev);
  endtask

  initial begin
    int highs;
    int seq [5];
    logic [4:0] ev0, ev1;
    logic [5:0] ra;
    logic [31:0] rdv;
    seq = '{1, 2, 0, 1, 2};

    // Reset and all-zero readback
    rstn = 1'b0;
    idle(2, 5'd0);
    rstn = 1'b1;
    chk("rst_ctrl",  {4'd0, ctrl_o}, 32'd0);
    chk("rst_pclk",  {31'd0, pclk_en_o}, 32'd1);
    chk("rst_irq",   {31'd0, irq_o}, 32'd0);
    chk("rst_fbba",  fbba_o, 32'd0);
    for (int i = 0; i < 16; i++) begin
      apb_read(6'(i << 2));
      chk("rst_read", last_rd, 32'd0);
    end
    idle(3, 5'd0);

    // Divider = 3
    apb_write(6'h00, 32'h0003_0000, 5'd0);
    highs = int'(pclk_en_o);
    for (int i = 0; i < 8; i++) begin
      idle(1, 5'd0);
      highs += int'(pclk_en_o);
    end
    chk("div3_count", 32'(highs), 32'd3);
    idle(1, 5'd0);
    apb_write(6'h00, 32'h0003_0000, 5'd0);
    chk("div_restart", {31'd0, pclk_en_o}, 32'd1);

    // Frame-synchronous shadow
    apb_write(6'h00, 32'h1, 5'd0);
    apb_write(6'h08, 32'h000A_0510, 5'd0);
    chk("htim_held", {8'd0, htim_o}, 32'd0);
    apb_read(6'h10);
    chk("pend_set", {31'd0, last_rd[4]}, 32'd1);
    idle(3, 5'd0);
    chk("htim_still_held", {8'd0, htim_o}, 32'd0);
    idle(1, 5'b00001);
    chk("htim_frame", {8'd0, htim_o}, 32'h000A_0510);
    apb_read(6'h10);
    chk("pend_clr", {31'd0, last_rd[4]}, 32'd0);
    apb_write(6'h08, 32'h0022_2222, 5'd0);
    apb_write(6'h08, 32'h0033_3333, 5'b00001);
    chk("htim_prewrite", {8'd0, htim_o}, 32'h0022_2222);
    apb_read(6'h10);
    chk("pend_kept", {31'd0, last_rd[4]}, 32'd1);
    idle(1, 5'b00001);
    chk("htim_next", {8'd0, htim_o}, 32'h0033_3333);

    // Framebuffer ring
    for (int i = 0; i < FBN; i++) apb_write(6'(32 + 4 * i), $urandom, 5'd0);
    apb_write(6'h00, 32'h11, 5'd0);
    apb_write(6'h14, 32'h2, 5'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1, 5'b01000);
      chk("fb_seq", {29'd0, fb_idx_o}, 32'(seq[i]));
    end
    apb_write(6'h14, 32'h7, 5'd0);
    apb_read(6'h14);
    chk("fb_clamp", last_rd, 32'h3);

    // Interrupt flag W1C
    apb_write(6'h00, 32'h3, 5'd0);
    apb_write(6'h10, 32'hF, 5'd0);
    idle(1, 5'b00010);
    chk("irq_set", {31'd0, irq_o}, 32'd1);
    apb_write(6'h10, 32'h1, 5'b00010);
    chk("irq_set_wins", {31'd0, irq_o}, 32'd1);
    apb_write(6'h10, 32'h1, 5'd0);
    chk("irq_clr", {31'd0, irq_o}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 5; k++) begin
        ev0[k] = ($urandom_range(0, 3) == 0);
        ev1[k] = ($urandom_range(0, 3) == 0);
      end
      ra  = 6'($urandom_range(0, 15) << 2);
      rdv = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          tick(1'b1, 1'b0, 1'b1, ra, rdv, ev0);
          tick(1'b1, 1'b1, 1'b1, ra, rdv, ev1);
        end
        1: begin
          tick(1'b1, 1'b0, 1'b0, ra, 32'd0, ev0);
          tick(1'b1, 1'b1, 1'b0, ra, 32'd0, ev1);
        end
        default: idle(1, ev0);
      endcase
    end

    // Underrun counter
    apb_write(6'h00, 32'h800, 5'd0);
    apb_write(6'h18, 32'h0, 5'd0);
`ifdef VGA_CFG_UFLOW_EN
    idle(32'h10005, 5'b10000);
    apb_read(6'h18);
    chk("uflow_sat", last_rd, 32'hFFFF);
    chk("uflow_irq", {31'd0, irq_o}, 32'd1);
    apb_write(6'h18, 32'h0, 5'd0);
    apb_read(6'h18);
    chk("uflow_clr", last_rd, 32'h0);
    apb_write(6'h18, 32'h0, 5'b10000);
    apb_read(6'h18);
    chk("uflow_wr_pulse", last_rd, 32'h1);
`else
    idle(5, 5'b10000);
    apb_read(6'h18);
    chk("uflow_off", last_rd, 32'h0);
    apb_read(6'h10);
    chk("uif_off", {31'd0, last_rd[3]}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
